fifo_ram_ctrl: RTL and testbench

- Single-clock FIFO controller that drives a simple dual-port RAM (write port, read port with 2-cycle registered read latency) as a circular buffer.
- Owns the read/write pointers, occupancy count, status flags and sticky error flags.
- Aligns a data-valid strobe with the RAM's delayed read data.
- Sits between a producer/consumer pair and the RAM instance; both RAM clocks are tied to clk.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_ptr.sv | 43 ++++
 rtl/fifo_ram_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fifo_ram_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO RAM controller:
//   READ_LATENCY - registered read latency of the attached simple dual-port RAM
//   PTR_W_MAX    - widest pointer the ptr_inc helper handles
//   ptr_inc()    - circular pointer increment with wrap at depth-1
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned READ_LATENCY = 2;
  localparam int unsigned PTR_W_MAX    = 32;

  // Advance a circular pointer; depth need not be a power of two.
  function automatic logic [PTR_W_MAX-1:0] ptr_inc(
    input logic [PTR_W_MAX-1:0] ptr,
    input logic [PTR_W_MAX-1:0] depth
  );
    logic [PTR_W_MAX-1:0] w_next;
    if (ptr == (depth - PTR_W_MAX'(1))) begin
      w_next = '0;
    end else begin
      w_next = ptr + PTR_W_MAX'(1);
    end
    return w_next;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Circular address pointer: advances on i_en, wraps from DEPTH-1 to 0,
// synchronous clear, asynchronous active-high reset.
// Ports:
//   i_clk    clock
//   i_reset  async active-high reset
//   i_clear  synchronous clear to 0 (priority over i_en)
//   i_en     advance by one entry
//   o_ptr    current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR  = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clear,
  input  logic            i_en,
  output logic [ADDR-1:0] o_ptr
);

  logic [ADDR-1:0] r_ptr;
  logic [ADDR-1:0] w_ptr_inc;

  assign w_ptr_inc = ADDR'(ptr_inc(PTR_W_MAX'(r_ptr), PTR_W_MAX'(DEPTH)));

  // Pointer register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= w_ptr_inc;
    end
  end

  assign o_ptr = r_ptr;

endmodule : fifo_ptr

// File: rtl/fifo_ram_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ram_ctrl
// Single-clock FIFO controller driving a simple dual-port RAM (2-cycle
// registered read) as a circular buffer. Owns pointers, occupancy, status
// flags, sticky error flags and the read-data valid strobe.
// Ports:
//   i_clk, i_reset        clock, async active-high reset (also feed the RAM)
//   i_clear               synchronous flush, priority over push/pop
//   i_push, i_push_data   write request and data
//   i_pop                 read request
//   o_pop_data            read data (pass-through of i_ram_rd_data)
//   o_pop_valid           o_pop_data valid this cycle
//   o_ram_wr_en/addr/data RAM write port (combinational)
//   o_ram_rd_en/addr      RAM read port (combinational)
//   i_ram_rd_data         RAM read data
//   o_count               occupancy, ADDR+1 bits
//   o_full, o_empty, o_almost_full, o_almost_empty  status decoded from count
//   o_overflow, o_underflow  sticky error flags
// -----------------------------------------------------------------------------
module fifo_ram_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR     = 10,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_pop_valid,
  output logic             o_ram_wr_en,
  output logic [ADDR-1:0]  o_ram_wr_addr,
  output logic [WIDTH-1:0] o_ram_wr_data,
  output logic             o_ram_rd_en,
  output logic [ADDR-1:0]  o_ram_rd_addr,
  input  logic [WIDTH-1:0] i_ram_rd_data,
  output logic [ADDR:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int unsigned CNT_W = ADDR + 1;

  logic [CNT_W-1:0]        r_count;
  logic [READ_LATENCY-1:0] r_vld;
  logic                    r_overflow;
  logic                    r_underflow;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [ADDR-1:0]         w_wr_ptr;
  logic [ADDR-1:0]         w_rd_ptr;
  logic [CNT_W-1:0]        w_count_next;

  // Status decoded from the count register only, never from inputs
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Clear wins over both requests; full rejects push, empty rejects pop
  assign w_wr_acc = i_push & ~w_full  & ~i_clear;
  assign w_rd_acc = i_pop  & ~w_empty & ~i_clear;

  // Write and read pointers
  fifo_ptr #(
    .ADDR  (ADDR),
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_en    (w_wr_acc),
    .o_ptr   (w_wr_ptr)
  );

  fifo_ptr #(
    .ADDR  (ADDR),
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_en    (w_rd_acc),
    .o_ptr   (w_rd_ptr)
  );

  // Acceptance rules keep this within 0..DEPTH without saturation logic
  assign w_count_next = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);

  // Occupancy counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  // Valid shift register matching the RAM's registered read latency
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vld <= '0;
    end else if (i_clear) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[READ_LATENCY-2:0], w_rd_acc};
    end
  end

  // Sticky error flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_push && w_full) begin
        r_overflow <= 1'b1;
      end
      if (i_pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // RAM ports
  assign o_ram_wr_en   = w_wr_acc;
  assign o_ram_wr_addr = w_wr_ptr;
  assign o_ram_wr_data = i_push_data;
  assign o_ram_rd_en   = w_rd_acc;
  assign o_ram_rd_addr = w_rd_ptr;

  // Consumer side
  assign o_pop_data  = i_ram_rd_data;
  assign o_pop_valid = r_vld[READ_LATENCY-1];

  // Status outputs
  assign o_count        = r_count;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= CNT_W'(AF_LEVEL));
  assign o_almost_empty = (r_count <= CNT_W'(AE_LEVEL));
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule : fifo_ram_ctrl

// File: tb/tb_fifo_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ram_ctrl
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a queue-based reference model. Includes a 2-cycle RAM model.
// -----------------------------------------------------------------------------
module tb_fifo_ram_ctrl;

  localparam int DEPTH = 6;
  localparam int WIDTH = 8;
  localparam int ADDR  = 3;
  localparam int AF    = 5;
  localparam int AE    = 1;

  logic             clk;
  logic             reset;
  logic             clear;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             ram_wr_en;
  logic [ADDR-1:0]  ram_wr_addr;
  logic [WIDTH-1:0] ram_wr_data;
  logic             ram_rd_en;
  logic [ADDR-1:0]  ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data;
  logic [ADDR:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  fifo_ram_ctrl #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .ADDR     (ADDR),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_clear        (clear),
    .i_push         (push),
    .i_push_data    (push_data),
    .i_pop          (pop),
    .o_pop_data     (pop_data),
    .o_pop_valid    (pop_valid),
    .o_ram_wr_en    (ram_wr_en),
    .o_ram_wr_addr  (ram_wr_addr),
    .o_ram_wr_data  (ram_wr_data),
    .o_ram_rd_en    (ram_rd_en),
    .o_ram_rd_addr  (ram_rd_addr),
    .i_ram_rd_data  (ram_rd_data),
    .o_count        (count),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty),
    .o_overflow     (overflow),
    .o_underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port RAM with read data registered twice
  logic [WIDTH-1:0] mem [2**ADDR];
  logic [WIDTH-1:0] ram_s1;
  logic [WIDTH-1:0] ram_s2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_s1 <= '0;
      ram_s2 <= '0;
    end else begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_en) ram_s1 <= mem[ram_rd_addr];
      ram_s2 <= ram_s1;
    end
  end

  assign ram_rd_data = ram_s2;

  // Reference model state
  typedef struct {
    int         cyc;
    logic [7:0] d;
  } ev_t;

  logic [7:0] mq[$];
  ev_t        sched[$];
  int         wr_idx;
  int         rd_idx;
  bit         m_ovf;
  bit         m_unf;
  int         cyc;

  int n_chk;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sched.delete();
    wr_idx = 0;
    rd_idx = 0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock cycle: drive, check against model, advance model past the edge
  task automatic step(input bit p, input logic [7:0] d, input bit r, input bit c);
    int n;
    bit wa;
    bit ra;
    bit ev;
    @(negedge clk);
    push = p; push_data = d; pop = r; clear = c;
    #1;
    cyc++;
    n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    ev = (sched.size() > 0) && (sched[0].cyc == cyc);
    chk("pop_valid", 32'(pop_valid), 32'(ev));
    if (ev) begin
      chk("pop_data", 32'(pop_data), 32'(sched[0].d));
      void'(sched.pop_front());
    end
    wa = p && (n < DEPTH) && !c;
    ra = r && (n > 0) && !c;
    chk("ram_wr_en", 32'(ram_wr_en), 32'(wa));
    chk("ram_rd_en", 32'(ram_rd_en), 32'(ra));
    if (wa) begin
      chk("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_idx));
      chk("ram_wr_data", 32'(ram_wr_data), 32'(d));
    end
    if (ra) chk("ram_rd_addr", 32'(ram_rd_addr), 32'(rd_idx));
    if (c) begin
      model_reset();
    end else begin
      if (p && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0)     m_unf = 1'b1;
      if (ra) begin
        ev_t e;
        e.cyc = cyc + 2;
        e.d   = mq.pop_front();
        sched.push_back(e);
        rd_idx = (rd_idx + 1) % DEPTH;
      end
      if (wa) begin
        mq.push_back(d);
        wr_idx = (wr_idx + 1) % DEPTH;
      end
    end
  endtask

  // Async reset between edges; outputs must react before the next edge
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int pw;
    int pr;
    n_chk = 0; n_err = 0; cyc = 0;
    reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("init_count", 32'(count), 32'd0);
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_pop_valid", 32'(pop_valid), 32'd0);
    chk("init_wr_en", 32'(ram_wr_en), 32'd0);
    reset = 1'b0;

    // Fill to full, then idle
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);

    // Full collision: pop accepted, push rejected
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("coll_full_ovf", 32'(overflow), 32'd1);
    chk("coll_full_cnt", 32'(count), 32'(DEPTH - 1));

    // Drain with back-to-back pops, including one past empty
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Clear, then wrap: push 4, pop 4, push 5
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Empty collision: push AA + pop on empty, then pop AA
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("coll_empty_unf", 32'(underflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush with a read in flight
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_pop_valid", 32'(pop_valid), 32'd0);
    chk("flush_count", 32'(count), 32'd0);

    // Async reset during back-to-back pops
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic with varying push/pop pressure
    pw = 50; pr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        pw = int'($urandom_range(10, 90));
        pr = int'($urandom_range(10, 90));
      end
      step(int'($urandom_range(0, 99)) < pw, 8'($urandom),
           int'($urandom_range(0, 99)) < pr, $urandom_range(0, 99) == 0);
      if (i % 700 == 350) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule : tb_fifo_ram_ctrl
